// File: rtl/mbus_pkg.sv
// Shared mbus definitions: bus widths, responder FSM states, request record
// and the window-relative word index helper.
package mbus_pkg;
  localparam int MBUS_ADDR_W = 48;
  localparam int MBUS_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mbus_rsp_state_t;

  typedef struct packed {
    logic                   re;
    logic                   we;
    logic [MBUS_ADDR_W-1:0] addr;
    logic [MBUS_DATA_W-1:0] wdata;
  } mbus_req_t;

  // Byte offset into the window, in 64-bit words; callers truncate to the RAM depth.
  function automatic logic [MBUS_ADDR_W-1:0] mbus_word_idx(
    input logic [MBUS_ADDR_W-1:0] addr,
    input logic [MBUS_ADDR_W-1:0] base
  );
    return (addr - base) >> 3;
  endfunction
endpackage

// File: rtl/mbus_ram_array.sv
// Single-port synchronous RAM with registered read; a drop-in slot for an SRAM macro.
module mbus_ram_array #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_idx] <= i_wdata;
      else      r_rdata      <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mbus_ram.sv
// mbus RAM target: window decode, request capture, programmable wait states,
// and a single-cycle ack/err response with read data.
module mbus_ram
  import mbus_pkg::*;
#(
  parameter logic [MBUS_ADDR_W-1:0] BASE_ADDR   = 48'h2000000,
  parameter int                     DEPTH_WORDS = 512,
  parameter int                     WAIT_STATES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mbus_re,
  input  logic                   mbus_we,
  input  logic [MBUS_ADDR_W-1:0] mbus_addr,
  input  logic [MBUS_DATA_W-1:0] mbus_wdata,
  output logic [MBUS_DATA_W-1:0] mbus_rdata,
  output logic                   mbus_ack,
  output logic                   mbus_err
);
  localparam int             IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [48:0]    WIN_LO  = {1'b0, BASE_ADDR};
  localparam logic [48:0]    WIN_HI  = WIN_LO + 49'(DEPTH_WORDS) * 49'd8;
  localparam logic [3:0]     WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  mbus_rsp_state_t        r_state;
  mbus_req_t              r_req;
  logic [3:0]             r_cnt;
  logic                   r_ack;
  logic                   r_err;
  logic                   r_rd_vld;
  logic [MBUS_DATA_W-1:0] r_rdata_hold;

  logic                   w_hit;
  logic                   w_bad;
  logic                   w_ram_en;
  logic [IDX_W-1:0]       w_idx;
  logic [MBUS_DATA_W-1:0] w_ram_rdata;

  // 49-bit compare so a window ending at the top of the address space cannot wrap.
  assign w_hit    = ({1'b0, mbus_addr} >= WIN_LO) && ({1'b0, mbus_addr} < WIN_HI);
  assign w_bad    = (r_req.re & r_req.we) | (r_req.addr[2:0] != 3'd0);
  assign w_idx    = IDX_W'(mbus_word_idx(r_req.addr, BASE_ADDR));
  assign w_ram_en = (r_state == RESP) && !w_bad && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_cnt        <= '0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_rd_vld <= 1'b0;
      if (r_rd_vld) r_rdata_hold <= w_ram_rdata;
      case (r_state)
        IDLE: begin
          if ((mbus_re | mbus_we) && w_hit) begin
            r_req   <= '{re: mbus_re, we: mbus_we, addr: mbus_addr, wdata: mbus_wdata};
            r_cnt   <= WS_INIT;
            r_state <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        RESP: begin
          r_state <= IDLE;
          if (w_bad) begin
            r_err <= 1'b1;
          end else begin
            r_ack    <= 1'b1;
            r_rd_vld <= r_req.re;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mbus_ram_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (IDX_W),
    .DW    (MBUS_DATA_W)
  ) u_array (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (r_req.we),
    .i_idx   (w_idx),
    .i_wdata (r_req.wdata),
    .o_rdata (w_ram_rdata)
  );

  // Fresh array data is shown in the ack cycle itself, otherwise the last read is held.
  assign mbus_rdata = r_rd_vld ? w_ram_rdata : r_rdata_hold;
  assign mbus_ack   = r_ack;
  assign mbus_err   = r_err;
endmodule

// File: tb/tb_mbus_ram.sv
// Directed bench for mbus_ram: vector table on a WAIT_STATES=2 instance plus
// hand sequences for reset abort, busy-time input changes and WAIT_STATES=0 streaming.
module tb_mbus_ram;
  import mbus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we, re0, we0;
  logic [47:0] addr, addr0;
  logic [63:0] wdata, wdata0, rdata, rdata0;
  logic        ack, err, ack0, err0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mbus_ram #(.BASE_ADDR(48'h2000000), .DEPTH_WORDS(512), .WAIT_STATES(2)) dut (
    .clk(clk), .rst_n(rst_n), .mbus_re(re), .mbus_we(we), .mbus_addr(addr),
    .mbus_wdata(wdata), .mbus_rdata(rdata), .mbus_ack(ack), .mbus_err(err));

  mbus_ram #(.BASE_ADDR(48'h2000000), .DEPTH_WORDS(512), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mbus_re(re0), .mbus_we(we0), .mbus_addr(addr0),
    .mbus_wdata(wdata0), .mbus_rdata(rdata0), .mbus_ack(ack0), .mbus_err(err0));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // resp: 0 none within bound, 1 ack, 2 err, 3 both; lat counted in edges after capture
  task automatic txn(input logic tre, input logic twe, input logic [47:0] ta,
                     input logic [63:0] twd, output int resp, output int lat,
                     output logic [63:0] rd);
    @(negedge clk);
    re = tre; we = twe; addr = ta; wdata = twd;
    resp = 0; lat = 0; rd = rdata;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (ack || err) begin
        resp = ack ? (err ? 3 : 1) : 2;
        lat  = c - 1;
        rd   = rdata;
        break;
      end
    end
    re = 1'b0; we = 1'b0;
    if (resp == 0) rd = rdata;
  endtask

  task automatic txn0(input logic tre, input logic twe, input logic [47:0] ta,
                      input logic [63:0] twd, output int resp, output logic [63:0] rd);
    @(negedge clk);
    re0 = tre; we0 = twe; addr0 = ta; wdata0 = twd;
    resp = 0; rd = rdata0;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (ack0 || err0) begin
        resp = ack0 ? (err0 ? 3 : 1) : 2;
        rd   = rdata0;
        break;
      end
    end
    re0 = 1'b0; we0 = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic        re;
    logic        we;
    logic [47:0] a;
    logic [63:0] wd;
    int          resp;
    logic [63:0] rd;
  } vec_t;

  vec_t        v[12];
  int          resp, lat, t1, t2;
  logic [63:0] rd, r1, r2;

  initial begin
    v[0]  = '{"wr_0x10",     1'b0, 1'b1, 48'h2000010, 64'hDEADBEEF_CAFEF00D, 1, 64'h0};
    v[1]  = '{"rd_0x10",     1'b1, 1'b0, 48'h2000010, 64'h0,                 1, 64'hDEADBEEF_CAFEF00D};
    v[2]  = '{"wr_last",     1'b0, 1'b1, 48'h2000FF8, 64'h01234567_89ABCDEF, 1, 64'hDEADBEEF_CAFEF00D};
    v[3]  = '{"rd_last",     1'b1, 1'b0, 48'h2000FF8, 64'h0,                 1, 64'h01234567_89ABCDEF};
    v[4]  = '{"rd_past_end", 1'b1, 1'b0, 48'h2001000, 64'h0,                 0, 64'h01234567_89ABCDEF};
    v[5]  = '{"rd_below",    1'b1, 1'b0, 48'h1FFFFF8, 64'h0,                 0, 64'h01234567_89ABCDEF};
    v[6]  = '{"wr_past_end", 1'b0, 1'b1, 48'h2001000, 64'h5555,              0, 64'h01234567_89ABCDEF};
    v[7]  = '{"rd_misalign", 1'b1, 1'b0, 48'h2000004, 64'h0,                 2, 64'h01234567_89ABCDEF};
    v[8]  = '{"rd_wr_dual",  1'b1, 1'b1, 48'h2000010, 64'h1111,              2, 64'h01234567_89ABCDEF};
    v[9]  = '{"rd_after_du", 1'b1, 1'b0, 48'h2000010, 64'h0,                 1, 64'hDEADBEEF_CAFEF00D};
    v[10] = '{"wr_0x20",     1'b0, 1'b1, 48'h2000020, 64'h1,                 1, 64'hDEADBEEF_CAFEF00D};
    v[11] = '{"rd_0x20",     1'b1, 1'b0, 48'h2000020, 64'h0,                 1, 64'h1};

    rst_n = 1'b0;
    re = 0; we = 0; addr = '0; wdata = '0;
    re0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",    64'(ack),   64'h0);
    chk("rst_err",    64'(err),   64'h0);
    chk("rst_rdata",  rdata,      64'h0);
    chk("rst_state",  64'(dut.r_state), 64'(IDLE));
    chk("rst_rdata0", rdata0,     64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      txn(v[i].re, v[i].we, v[i].a, v[i].wd, resp, lat, rd);
      chk({v[i].nm, "_resp"}, 64'(resp), 64'(v[i].resp));
      if (v[i].resp != 0) chk({v[i].nm, "_lat"}, 64'(lat), 64'd3);
      else                chk({v[i].nm, "_idle"}, 64'(dut.r_state), 64'(IDLE));
      chk({v[i].nm, "_rdata"}, rd, v[i].rd);
    end

    // Reset while a write to 0x20 is waiting: nothing reported, RAM keeps its old word.
    @(negedge clk);
    we = 1'b1; addr = 48'h2000020; wdata = 64'hBAD0_BAD0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ack",   64'(ack), 64'h0);
    chk("midrst_err",   64'(err), 64'h0);
    chk("midrst_rdata", rdata,    64'h0);
    chk("midrst_state", 64'(dut.r_state), 64'(IDLE));
    we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_noack", 64'(ack | err), 64'h0);
    txn(1'b1, 1'b0, 48'h2000020, 64'h0, resp, lat, rd);
    chk("midrst_rd_resp",  64'(resp), 64'd1);
    chk("midrst_rd_rdata", rd,        64'h1);

    // Address/data wiggle during WAIT must not redirect the captured write.
    txn(1'b0, 1'b1, 48'h2000038, 64'h3838, resp, lat, rd);
    chk("busy_pre_resp", 64'(resp), 64'd1);
    @(negedge clk);
    we = 1'b1; addr = 48'h2000030; wdata = 64'h3030;
    @(posedge clk); #1;
    addr = 48'h2000038; wdata = 64'hFFFF_FFFF;
    resp = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (ack || err) begin resp = ack ? 1 : 2; lat = c; break; end
    end
    we = 1'b0;
    chk("busy_wr_resp", 64'(resp), 64'd1);
    chk("busy_wr_lat",  64'(lat),  64'd3);
    txn(1'b1, 1'b0, 48'h2000030, 64'h0, resp, lat, rd);
    chk("busy_rd30", rd, 64'h3030);
    txn(1'b1, 1'b0, 48'h2000038, 64'h0, resp, lat, rd);
    chk("busy_rd38", rd, 64'h3838);

    // WAIT_STATES=0: a request held through ack retriggers two cycles later.
    txn0(1'b0, 1'b1, 48'h2000000, 64'hA0A0, resp, rd);
    chk("ws0_wr0_resp", 64'(resp), 64'd1);
    txn0(1'b0, 1'b1, 48'h2000008, 64'hB8B8, resp, rd);
    chk("ws0_wr8_resp", 64'(resp), 64'd1);
    @(negedge clk);
    re0 = 1'b1; addr0 = 48'h2000000;
    t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (ack0) begin
        if (t1 < 0) begin t1 = c; r1 = rdata0; addr0 = 48'h2000008; end
        else begin t2 = c; r2 = rdata0; break; end
      end
    end
    re0 = 1'b0;
    chk("ws0_lat",     64'(t1),      64'd2);
    chk("ws0_spacing", 64'(t2 - t1), 64'd2);
    chk("ws0_rd0",     r1,           64'hA0A0);
    chk("ws0_rd8",     r2,           64'hB8B8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ws0_no_third", 64'(ack0 | err0), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
